pc_call_stack: RTL

Parametrised program counter with an integrated return-address stack, the next-generation sequencer for the soft-CPU control path. It adds configurable address/offset widths, a pipeline stall input, and hardware subroutine call/return to the existing reset/load/relative-branch/increment behaviour. The instruction fetch stage consumes `CounterValue` directly as the instruction-memory address.

---
 rtl/pc_pkg.sv | 19 +
 rtl/return_stack.sv | 49 ++++
 rtl/pc_call_stack.sv | 102 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and default sizing for the program-counter sequencer.
package pc_pkg;

    localparam int DEF_WIDTH        = 16;
    localparam int DEF_OFFSET_WIDTH = 9;
    localparam int DEF_DEPTH        = 8;

    // Next-PC source, one per priority level of the sequencer.
    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_RESET,
        SEL_RETURN,
        SEL_CALL,
        SEL_LOAD,
        SEL_OFFSET,
        SEL_INC
    } pc_sel_t;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses. The write pointer is the entry count; the
// caller is responsible for never pushing when full or popping when empty.
module return_stack
    import pc_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    // When empty the read index wraps to DEPTH-1; the value is unused then.
    assign wr_idx   = count[AW-1:0];
    assign rd_idx   = AW'(count - CW'(1));
    assign top_data = mem[rd_idx];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

    // Entry count: push and pop are mutually exclusive upstream.
    always_ff @(posedge Clock) begin
        if (Reset)
            count <= '0;
        else if (push)
            count <= count + CW'(1);
        else if (pop)
            count <= count - CW'(1);
    end

    // Storage has no reset; contents past count are don't-care.
    always_ff @(posedge Clock) begin
        if (!Reset && push)
            mem[wr_idx] <= push_data;
    end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with reset/stall/return/call/load/branch/increment
// priority and a hardware return-address stack.
module pc_call_stack
    import pc_pkg::*;
#(
    parameter  int WIDTH        = DEF_WIDTH,
    parameter  int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
    parameter  int DEPTH        = DEF_DEPTH,
    localparam int CW           = $clog2(DEPTH) + 1
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           Stall,
    input  logic [WIDTH-1:0]               LoadValue,
    input  logic                           LoadEnable,
    input  logic signed [OFFSET_WIDTH-1:0] Offset,
    input  logic                           OffsetEnable,
    input  logic                           Call,
    input  logic                           Return,
    output logic [WIDTH-1:0]               CounterValue,
    output logic [CW-1:0]                  StackCount,
    output logic                           StackFull,
    output logic                           StackEmpty,
    output logic                           Overflow,
    output logic                           Underflow
);

    pc_sel_t          sel;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_branch;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] top_data;
    logic             push;
    logic             pop;

    // Sized cast of a signed operand sign-extends; sums wrap modulo 2^WIDTH.
    assign pc_inc    = CounterValue + WIDTH'(1);
    assign pc_branch = CounterValue + WIDTH'(Offset);

    // Only real pushes/pops reach the stack; full/empty attempts just flag.
    assign push = (sel == SEL_CALL)   && !StackFull;
    assign pop  = (sel == SEL_RETURN) && !StackEmpty;

    // Priority decoder for the next-PC source.
    always_comb begin
        sel = SEL_INC;
        if (Reset)             sel = SEL_RESET;
        else if (Stall)        sel = SEL_HOLD;
        else if (Return)       sel = SEL_RETURN;
        else if (Call)         sel = SEL_CALL;
        else if (LoadEnable)   sel = SEL_LOAD;
        else if (OffsetEnable) sel = SEL_OFFSET;
    end

    // Next-PC mux; an empty-stack return falls through to increment.
    always_comb begin
        pc_next = pc_inc;
        case (sel)
            SEL_HOLD:   pc_next = CounterValue;
            SEL_RESET:  pc_next = '0;
            SEL_RETURN: pc_next = StackEmpty ? pc_inc : top_data;
            SEL_CALL:   pc_next = LoadValue;
            SEL_LOAD:   pc_next = LoadValue;
            SEL_OFFSET: pc_next = pc_branch;
            default:    pc_next = pc_inc;
        endcase
    end

    // PC register.
    always_ff @(posedge Clock) begin
        CounterValue <= pc_next;
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            if (sel == SEL_CALL && StackFull)
                Overflow <= 1'b1;
            if (sel == SEL_RETURN && StackEmpty)
                Underflow <= 1'b1;
        end
    end

    return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .Clock     (Clock),
        .Reset     (Reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top_data  (top_data),
        .count     (StackCount),
        .full      (StackFull),
        .empty     (StackEmpty)
    );

endmodule
